// File: rtl/vblank_write_queue_if.sv
// vblank_write_queue_if: producer/video-bus bundle for the vblank write queue.
//   push, push_addr, push_data : enqueue request from the producer
//   full, empty, count         : registered occupancy status
//   overflow                   : sticky "a push was dropped" flag
//   vsync                      : vertical-blank window (level)
//   addr, data, rw             : video bus write port (rw = 1 means write this cycle)
// master: producer / timing side. slave: the queue itself.
interface vblank_write_queue_if #(
    parameter int unsigned DEPTH = 16
);
    logic                      push;
    logic [15:0]               push_addr;
    logic [7:0]                push_data;
    logic                      full;
    logic                      empty;
    logic [$clog2(DEPTH):0]    count;
    logic                      overflow;
    logic                      vsync;
    logic [15:0]               addr;
    logic [7:0]                data;
    logic                      rw;

    modport master (
        output push, push_addr, push_data, vsync,
        input  full, empty, count, overflow, addr, data, rw
    );

    modport slave (
        input  push, push_addr, push_data, vsync,
        output full, empty, count, overflow, addr, data, rw
    );
endinterface

// File: rtl/vblank_write_queue.sv
// vblank_write_queue: buffers CPU writes to video memory and replays them onto the
// video bus only while vsync (vertical blank) is high, one write per clock.
//   clk   : single clock, all state on posedge
//   reset : asynchronous, active-low
//   bus   : vblank_write_queue_if.slave (push side, status, video bus write port)
// Optional feature macro: VWQ_LIMIT_EN -- caps pops per vsync window to MAX_PER_FRAME.
module vblank_write_queue #(
    parameter int unsigned DEPTH         = 16,
    parameter int unsigned MAX_PER_FRAME = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    vblank_write_queue_if.slave   bus
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    if (DEPTH < 2 || DEPTH > 256 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("DEPTH must be a power of two in 2..256");
    end
    if (MAX_PER_FRAME < 1) begin : g_bad_max
        $error("MAX_PER_FRAME must be at least 1");
    end

    typedef enum logic {StIdle, StDrain} state_e;

    state_e            state_q, state_d;
    logic [23:0]       mem_q [DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]   count_q, count_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              overflow_q, overflow_d;
    logic [15:0]       addr_q, addr_d;
    logic [7:0]        data_q, data_d;
    logic              rw_q, rw_d;
    logic              do_push, do_pop, limit_ok;
    logic [23:0]       rd_entry;

    // Full takes precedence: a push while full is dropped even if a pop happens too.
    assign do_push  = bus.push && !full_q;
    assign do_pop   = (state_q == StDrain) && bus.vsync && !empty_q && limit_ok;
    assign rd_entry = mem_q[rd_ptr_q];

`ifdef VWQ_LIMIT_EN
    localparam int unsigned FrmW = $clog2(MAX_PER_FRAME + 1);
    logic [FrmW-1:0] frame_cnt_q, frame_cnt_d;

    assign limit_ok = frame_cnt_q < FrmW'(MAX_PER_FRAME);

    // Counts pops in the current vsync window; only a low vsync re-arms it.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (!bus.vsync) begin
            frame_cnt_d = '0;
        end else if (do_pop) begin
            frame_cnt_d = frame_cnt_q + FrmW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end
`else
    assign limit_ok = 1'b1;
`endif

    always_comb begin
        wr_ptr_d   = do_push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
        rd_ptr_d   = do_pop  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
        count_d    = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CntW'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - CntW'(1);
        end
        full_d     = (count_d == CntW'(DEPTH));
        empty_d    = (count_d == '0);
        overflow_d = overflow_q || (bus.push && full_q);
        rw_d       = do_pop;
        addr_d     = do_pop ? rd_entry[23:8] : addr_q;
        data_d     = do_pop ? rd_entry[7:0]  : data_q;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (bus.vsync && !empty_q) state_d = StDrain;
            StDrain: if (!bus.vsync || empty_d) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
            addr_q     <= 16'h0000;
            data_q     <= 8'h00;
            rw_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            overflow_q <= overflow_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            rw_q       <= rw_d;
        end
    end

    // Storage needs no reset: occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= {bus.push_addr, bus.push_data};
        end
    end

    assign bus.full     = full_q;
    assign bus.empty    = empty_q;
    assign bus.count    = count_q;
    assign bus.overflow = overflow_q;
    assign bus.addr     = addr_q;
    assign bus.data     = data_q;
    assign bus.rw       = rw_q;
endmodule

// File: tb/tb_vblank_write_queue.sv
module tb_vblank_write_queue;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned MAXF  = 4;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;
    int   n_wr;
    logic [23:0] sb[$];

    vblank_write_queue_if #(.DEPTH(DEPTH)) bus ();

    vblank_write_queue #(
        .DEPTH         (DEPTH),
        .MAX_PER_FRAME (MAXF)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One clock; sample just after the edge and score any bus write against the model.
    task automatic cycle();
        logic [23:0] e;
        @(posedge clk);
        #1;
        if (bus.rw === 1'b1) begin
            n_wr++;
            if (sb.size() == 0) begin
                check("rw_spurious", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("write", {8'h00, bus.addr, bus.data}, {8'h00, e});
            end
        end
    endtask

    task automatic push_entry(input logic [15:0] a, input logic [7:0] d);
        bus.push      = 1'b1;
        bus.push_addr = a;
        bus.push_data = d;
        if (sb.size() < DEPTH) sb.push_back({a, d});
        cycle();
        bus.push = 1'b0;
    endtask

    task automatic vsync_window(input int n);
        bus.vsync = 1'b1;
        for (int i = 0; i < n; i++) cycle();
        bus.vsync = 1'b0;
        cycle();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_count"}, 32'(bus.count), 32'd0);
        check({tag, "_empty"}, 32'(bus.empty), 32'd1);
        check({tag, "_full"}, 32'(bus.full), 32'd0);
        check({tag, "_ovf"}, 32'(bus.overflow), 32'd0);
        check({tag, "_rw"}, 32'(bus.rw), 32'd0);
        check({tag, "_addr"}, 32'(bus.addr), 32'h0000);
        check({tag, "_data"}, 32'(bus.data), 32'h00);
    endtask

    initial begin
        int first;
        int last;
        int w0;
        n_checks = 0;
        n_fail   = 0;
        n_wr     = 0;
        reset         = 1'b0;
        bus.push      = 1'b0;
        bus.push_addr = 16'h0;
        bus.push_data = 8'h0;
        bus.vsync     = 1'b0;
        cycle();
        cycle();
        check_reset_outputs("reset");
        reset = 1'b1;
        cycle();

        // Three writes, replay order and latency from vsync rise.
        push_entry(16'hF005, 8'h41);
        push_entry(16'hEFF8, 8'h50);
        push_entry(16'hF203, 8'h07);
        check("three_count", 32'(bus.count), 32'd3);
        first = 0;
        last  = 0;
        w0    = n_wr;
        bus.vsync = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            cycle();
            if (bus.rw === 1'b1) begin
                if (first == 0) first = i;
                last = i;
            end
        end
        bus.vsync = 1'b0;
        cycle();
        check("three_first", 32'(first), 32'd2);
        check("three_consec", 32'(last - first), 32'd2);
        check("three_writes", 32'(n_wr - w0), 32'd3);
        check("three_empty", 32'(bus.empty), 32'd1);
        check("three_rw_low", 32'(bus.rw), 32'd0);
        check("hold_addr", 32'(bus.addr), 32'hF203);
        check("hold_data", 32'(bus.data), 32'h07);

        // Push and pop every cycle: occupancy stays constant.
        for (int i = 0; i < 5; i++) push_entry(16'h2000 + 16'(i), 8'(8'h10 + i));
        bus.vsync = 1'b1;
        cycle();
        w0 = n_wr;
        for (int i = 0; i < 20; i++) begin
            push_entry(16'h2100 + 16'(i), 8'(8'h80 + i));
            check("steady_count", 32'(bus.count), 32'd5);
        end
        bus.vsync = 1'b0;
        cycle();
        check("steady_writes", 32'(n_wr - w0), 32'd20);
        check("steady_ovf", 32'(bus.overflow), 32'd0);
        vsync_window(8);
        check("steady_empty", 32'(bus.empty), 32'd1);

        // Short window drains 3, the rest waits for the next window.
        for (int i = 0; i < 10; i++) push_entry(16'h3000 + 16'(i), 8'(8'h30 + i));
        w0 = n_wr;
        vsync_window(4);
        check("short_writes", 32'(n_wr - w0), 32'd3);
        check("short_count", 32'(bus.count), 32'd7);
        cycle();
        vsync_window(12);
        check("short_rest", 32'(n_wr - w0), 32'd10);
        check("short_empty", 32'(bus.empty), 32'd1);

        // Overflow: DEPTH+1 pushes, last one dropped.
        for (int i = 0; i <= DEPTH; i++) push_entry(16'h4000 + 16'(i), 8'(i));
        check("ovf_full", 32'(bus.full), 32'd1);
        check("ovf_count", 32'(bus.count), 32'(DEPTH));
        check("ovf_flag", 32'(bus.overflow), 32'd1);
        w0 = n_wr;
        vsync_window(DEPTH + 4);
        check("ovf_writes", 32'(n_wr - w0), 32'(DEPTH));
        check("ovf_empty", 32'(bus.empty), 32'd1);
        check("ovf_sticky", 32'(bus.overflow), 32'd1);

        // Reset in the middle of a drain.
        for (int i = 0; i < 8; i++) push_entry(16'h5000 + 16'(i), 8'(8'h50 + i));
        bus.vsync = 1'b1;
        cycle();
        cycle();
        cycle();
        reset = 1'b0;
        #2;
        check_reset_outputs("midrst");
        sb.delete();
        cycle();
        reset = 1'b1;
        w0 = n_wr;
        for (int i = 0; i < 10; i++) cycle();
        bus.vsync = 1'b0;
        cycle();
        check("midrst_writes", 32'(n_wr - w0), 32'd0);

        // Per-frame cap (only when the limit feature is built in).
        for (int i = 0; i < 10; i++) push_entry(16'h6000 + 16'(i), 8'(8'h60 + i));
        w0 = n_wr;
        vsync_window(20);
`ifdef VWQ_LIMIT_EN
        check("lim_win1", 32'(n_wr - w0), 32'(MAXF));
        w0 = n_wr;
        vsync_window(20);
        check("lim_win2", 32'(n_wr - w0), 32'(MAXF));
        vsync_window(20);
`else
        check("nolim_win1", 32'(n_wr - w0), 32'd10);
`endif
        check("lim_empty", 32'(bus.empty), 32'd1);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/vblank_write_queue.md
VBLANK_WRITE_QUEUE -- requirements
Module: vblank_write_queue

Interface
REQ-001 Parameter DEPTH, default 16, FIFO entry count; SHALL be a power of two, 2..256.
REQ-002 Parameter MAX_PER_FRAME, default 32, cap on writes drained per vsync interval (used only with VWQ_LIMIT_EN).
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  asynchronous, active-low; asserted when 0.
REQ-005 push  input  1  enqueue request from producer.
REQ-006 push_addr  input  16  bus address to write.
REQ-007 push_data  input  8  byte to write.
REQ-008 full  output  1  FIFO holds DEPTH entries.
REQ-009 empty  output  1  FIFO holds 0 entries.
REQ-010 count  output  $clog2(DEPTH)+1  current occupancy.
REQ-011 overflow  output  1  sticky: a push was dropped.
REQ-012 vsync  input  1  vertical-blank window from the LCD timing generator; level-sensitive.
REQ-013 addr  output  16  video bus address to textbuffer/sprite decode.
REQ-014 data  output  8  video bus write data.
REQ-015 rw  output  1  video bus write strobe, 1 = write this cycle.

Function
REQ-016 Entries SHALL be stored as {push_addr, push_data} in a circular FIFO with wrapping read/write pointers of $clog2(DEPTH) bits.
REQ-017 push with full=0 SHALL store the entry at the write pointer and increment it on the same clock edge.
REQ-018 push with full=1 SHALL drop the entry, leave FIFO contents unchanged and set overflow to 1.
REQ-019 State machine SHALL have states IDLE and DRAIN; IDLE->DRAIN when vsync=1 and empty=0; DRAIN->IDLE when vsync=0 or FIFO becomes empty after a pop.
REQ-020 In DRAIN, each clock SHALL pop one entry and register it onto addr/data with rw=1 the following cycle (one-cycle latency from pop to bus).
REQ-021 rw SHALL be 0 in every cycle with no pop in the previous cycle; addr/data SHALL hold their last value when rw=0.
REQ-022 vsync falling while in DRAIN SHALL stop popping on that edge; entries not yet popped SHALL remain for the next vsync.
REQ-023 Simultaneous push and pop SHALL both take effect; count unchanged; push accepted even when full=1 in that cycle is not required (full takes precedence, entry dropped).
REQ-024 Push into an empty FIFO during vsync=1 SHALL be eligible for pop no earlier than the next clock.
REQ-025 count, full, empty SHALL be registered and consistent with each other every cycle.

Reset
REQ-026 reset=0 SHALL asynchronously force: pointers 0, count 0, empty 1, full 0, overflow 0, state IDLE, rw 0, addr 16'h0000, data 8'h00.
REQ-027 reset asserted mid-DRAIN SHALL discard all queued entries; no rw pulse SHALL appear after reset deassertion until a new push and vsync.
REQ-028 overflow SHALL clear only on reset.

Configuration
REQ-029 With macro VWQ_LIMIT_EN defined, a per-frame counter SHALL count pops, clear when vsync=0, and block popping once it reaches MAX_PER_FRAME until vsync deasserts and reasserts.
REQ-030 Without VWQ_LIMIT_EN, draining SHALL continue every cycle while vsync=1 and empty=0; MAX_PER_FRAME SHALL be ignored.

Verification
REQ-031 Push 3 entries (F005/41, EFF8/50, F203/07) with vsync=0, then vsync=1 for 10 cycles -> 3 consecutive rw=1 cycles in push order, first one 2 cycles after vsync rises, then rw=0, empty=1.
REQ-032 Push DEPTH+1 entries with vsync=0 -> full=1, count=DEPTH, overflow=1; drain yields exactly DEPTH writes, the last pushed entry absent.
REQ-033 Push 10 entries, vsync=1 for 4 cycles -> 3 writes (entries 0-2), count=7; next vsync window drains entries 3-9 in order.
REQ-034 Push every cycle during a 20-cycle vsync window with FIFO initially holding 5 -> count stays 5 throughout, no overflow, writes emerge in FIFO order.
REQ-035 Queue 8 entries, pull reset low for 1 cycle during DRAIN -> all outputs at reset values immediately, no further rw pulses in the next vsync window.
REQ-036 VWQ_LIMIT_EN, MAX_PER_FRAME=4, 10 entries queued, vsync held 20 cycles -> exactly 4 writes; after vsync low/high, next 4 writes.
